// File: rtl/alu_result_tx.sv
// Result return stage: buffers ALU results in a small FIFO and serialises each one
// as NBYTES data bytes (LSB first) plus a status byte into the UART transmit handshake.
module alu_result_tx #(
  parameter  int DATA_WIDTH = 18,
  parameter  int DEPTH      = 4,
  localparam int NBYTES     = (DATA_WIDTH + 7) / 8,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic                  i_ovf,
  input  logic                  i_zero,
  input  logic                  i_busy_tx,
  input  logic                  i_clr_overrun,
  output logic                  o_transmit,
  output logic [7:0]            o_data_tx,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [LW-1:0]         o_level,
  output logic                  o_overrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam int SW = NBYTES * 8;
  localparam int IW = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overrun_q, overrun_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [1:0]      st_q, st_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            transmit_q, transmit_d;
  logic [7:0]      data_tx_q, data_tx_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic            full, empty, push, pop, drop, last;
  logic [EW-1:0]   head;
  logic [7:0]      cur_byte;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign head     = mem_q[rd_ptr_q];
  assign last     = (idx_q == IW'(NBYTES));
  // Index NBYTES selects the status byte; below it the shifter supplies data bytes.
  assign cur_byte = last ? {6'd0, st_q} : shift_q[7:0];
  assign pop      = (state_q == IDLE) && !empty && !i_busy_tx;
  assign push     = i_valid && (!full || pop);
  assign drop     = i_valid && full && !pop;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    st_d       = st_q;
    idx_d      = idx_q;
    transmit_d = 1'b0;
    data_tx_d  = data_tx_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    overrun_d  = drop ? 1'b1 : (i_clr_overrun ? 1'b0 : overrun_q);

    unique case (state_q)
      IDLE: if (pop) begin
        shift_d = SW'(head[DATA_WIDTH-1:0]);
        st_d    = head[EW-1:EW-2];
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        // Strobe and byte are registered so both stay aligned at the UART.
        transmit_d = 1'b1;
        data_tx_d  = cur_byte;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: if (i_busy_tx) state_d = WAIT_DONE;
      WAIT_DONE: if (!i_busy_tx) begin
        if (last) begin
          state_d = IDLE;
        end else begin
          shift_d = shift_q >> 8;
          idx_d   = idx_q + IW'(1);
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
      shift_q    <= '0;
      st_q       <= '0;
      idx_q      <= '0;
      transmit_q <= 1'b0;
      data_tx_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      shift_q    <= shift_d;
      st_q       <= st_d;
      idx_q      <= idx_d;
      transmit_q <= transmit_d;
      data_tx_q  <= data_tx_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_ovf, i_zero, i_q};
  end

  assign o_transmit = transmit_q;
  assign o_data_tx  = data_tx_q;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_level    = level_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: a vector table of single-result frames plus
// hand sequences for burst, overrun, push-on-pop while full and mid-frame reset.
module tb_alu_result_tx;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_valid;
  logic [17:0] i_q;
  logic        i_ovf, i_zero;
  logic        i_busy_tx;
  logic        i_clr_overrun;
  logic        o_transmit;
  logic [7:0]  o_data_tx;
  logic        o_full, o_empty;
  logic [2:0]  o_level;
  logic        o_overrun;

  alu_result_tx #(.DATA_WIDTH(18), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_valid(i_valid), .i_q(i_q), .i_ovf(i_ovf),
    .i_zero(i_zero), .i_busy_tx(i_busy_tx), .i_clr_overrun(i_clr_overrun),
    .o_transmit(o_transmit), .o_data_tx(o_data_tx), .o_full(o_full), .o_empty(o_empty),
    .o_level(o_level), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // UART model: each strobe captures a byte and holds busy for 10 cycles.
  logic       force_busy = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  assign i_busy_tx = force_busy | (busy_cnt != 0);

  initial forever begin
    @(negedge i_clk);
    if (o_transmit === 1'b1) begin
      rxq.push_back(o_data_tx);
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
  end

  typedef struct {
    logic [17:0]     q;
    logic            ovf;
    logic            zero;
    logic [3:0][7:0] b;
  } vec_t;

  vec_t vec[4];
  int   n_vec = 0;
  int   n_miss = 0;
  int   nrx;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [17:0] q, input logic ovf, input logic zero);
    i_q = q; i_ovf = ovf; i_zero = zero; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic exp_frame(input logic [17:0] q, input logic ovf, input logic zero);
    logic [23:0] w;
    w = {6'd0, q};
    expq.push_back(w[7:0]);
    expq.push_back(w[15:8]);
    expq.push_back(w[23:16]);
    expq.push_back({6'd0, ovf, zero});
  endtask

  task automatic drain_check(input string nm);
    int n, t;
    n = expq.size();
    t = 0;
    while (rxq.size() < n && t < 3000) begin
      @(negedge i_clk);
      t++;
    end
    if (rxq.size() < n) begin
      check({nm, " timeout bytes"}, rxq.size(), n);
      expq.delete();
      rxq.delete();
    end else begin
      for (int k = 0; k < n; k++)
        check($sformatf("%s byte%0d", nm, k), rxq.pop_front(), expq.pop_front());
    end
  endtask

  initial begin
    vec[0] = '{q: 18'h2A5C3, ovf: 1'b0, zero: 1'b0, b: {8'h00, 8'h02, 8'hA5, 8'hC3}};
    vec[1] = '{q: 18'h00000, ovf: 1'b0, zero: 1'b1, b: {8'h01, 8'h00, 8'h00, 8'h00}};
    vec[2] = '{q: 18'h3FFFF, ovf: 1'b1, zero: 1'b0, b: {8'h02, 8'h03, 8'hFF, 8'hFF}};
    vec[3] = '{q: 18'h10080, ovf: 1'b1, zero: 1'b1, b: {8'h03, 8'h01, 8'h00, 8'h80}};

    i_nrst = 1'b0; i_valid = 1'b0; i_q = '0; i_ovf = 1'b0; i_zero = 1'b0;
    i_clr_overrun = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst transmit", o_transmit, 1'b0);
    check("rst data_tx", o_data_tx, 8'h00);
    check("rst full", o_full, 1'b0);
    check("rst empty", o_empty, 1'b1);
    check("rst level", o_level, 3'd0);
    check("rst overrun", o_overrun, 1'b0);
    i_nrst = 1'b1;
    @(negedge i_clk);

    // First-frame latency: strobe two cycles after the push edge.
    i_q = 18'h2A5C3; i_ovf = 1'b0; i_zero = 1'b0; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("lat N+0 transmit", o_transmit, 1'b0);
    check("lat N+0 level", o_level, 3'd1);
    check("lat N+0 empty", o_empty, 1'b0);
    @(negedge i_clk);
    check("lat N+1 transmit", o_transmit, 1'b0);
    @(negedge i_clk);
    check("lat N+2 transmit", o_transmit, 1'b1);
    check("lat N+2 data", o_data_tx, 8'hC3);
    exp_frame(18'h2A5C3, 1'b0, 1'b0);
    drain_check("lat");
    repeat (15) @(negedge i_clk);

    for (int i = 0; i < 4; i++) begin
      push(vec[i].q, vec[i].ovf, vec[i].zero);
      for (int k = 0; k < 4; k++) expq.push_back(vec[i].b[k]);
      drain_check($sformatf("vec%0d", i));
      repeat (15) @(negedge i_clk);
    end

    // Burst of four with UART held busy so the FIFO fills.
    force_busy = 1'b1;
    @(negedge i_clk);
    push(18'd1, 1'b0, 1'b0);
    push(18'd2, 1'b0, 1'b0);
    push(18'd3, 1'b1, 1'b0);
    push(18'd4, 1'b0, 1'b0);
    check("burst full", o_full, 1'b1);
    check("burst level", o_level, 3'd4);
    exp_frame(18'd1, 1'b0, 1'b0);
    exp_frame(18'd2, 1'b0, 1'b0);
    exp_frame(18'd3, 1'b1, 1'b0);
    exp_frame(18'd4, 1'b0, 1'b0);
    force_busy = 1'b0;
    drain_check("burst");
    check("burst overrun", o_overrun, 1'b0);
    repeat (15) @(negedge i_clk);
    check("burst empty", o_empty, 1'b1);

    // Overrun: fifth result dropped; clear loses to a simultaneous drop.
    force_busy = 1'b1;
    @(negedge i_clk);
    for (int i = 0; i < 4; i++) push(18'(11 + i), 1'b0, 1'b0);
    push(18'd5, 1'b0, 1'b0);
    check("ovr overrun set", o_overrun, 1'b1);
    check("ovr level", o_level, 3'd4);
    i_clr_overrun = 1'b1;
    push(18'd6, 1'b0, 1'b0);
    check("ovr clr vs drop", o_overrun, 1'b1);
    @(negedge i_clk);
    i_clr_overrun = 1'b0;
    check("ovr cleared", o_overrun, 1'b0);
    check("ovr level held", o_level, 3'd4);
    for (int i = 0; i < 4; i++) exp_frame(18'(11 + i), 1'b0, 1'b0);
    force_busy = 1'b0;
    drain_check("ovr");
    repeat (20) @(negedge i_clk);
    check("ovr no extra bytes", rxq.size(), 0);

    // Full FIFO: push lands on the same edge as the IDLE pop.
    force_busy = 1'b1;
    @(negedge i_clk);
    for (int i = 0; i < 4; i++) push(18'(21 + i), 1'b0, 1'b0);
    check("pp full", o_full, 1'b1);
    force_busy = 1'b0;
    push(18'd25, 1'b1, 1'b1);
    check("pp level", o_level, 3'd4);
    check("pp overrun", o_overrun, 1'b0);
    for (int i = 0; i < 4; i++) exp_frame(18'(21 + i), 1'b0, 1'b0);
    exp_frame(18'd25, 1'b1, 1'b1);
    drain_check("pp");
    repeat (15) @(negedge i_clk);

    // Reset after the second byte of a frame, with one more result queued.
    push(18'h2A5C3, 1'b0, 1'b0);
    push(18'h12345, 1'b0, 1'b0);
    for (int t = 0; t < 500 && rxq.size() < 2; t++) @(negedge i_clk);
    check("mid bytes before rst", rxq.size(), 2);
    #2 i_nrst = 1'b0;
    #1;
    check("mid rst transmit", o_transmit, 1'b0);
    check("mid rst data_tx", o_data_tx, 8'h00);
    check("mid rst level", o_level, 3'd0);
    check("mid rst empty", o_empty, 1'b1);
    check("mid rst full", o_full, 1'b0);
    check("mid rst overrun", o_overrun, 1'b0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    nrx = rxq.size();
    repeat (60) @(negedge i_clk);
    check("mid no bytes after", rxq.size(), nrx);
    check("mid empty after", o_empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
